unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-ported unified memory between the Fetch stage (instruction reads) and the Memory stage (data loads and stores) of the 5-stage pipeline. It arbitrates requests, with data priority, and holds the memory request stable until the memory acknowledges. It returns read data to the winning requester and drives stallF/stallM to the pipeline until that requester's access completes. It sits between Fetch/memory_cycle and the memory, and replaces the separate IM/Data_Memory pair in the unified-memory configuration.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNT_W, 16, width of the saturating conflict counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- ifreq  in  1  fetch request (level); held until ifvalid or dropped on redirect
- ifaddr  in  ADDR_W  fetch address, sampled at grant
- ifrdata  out  DATA_W  fetched instruction, valid while ifvalid
- ifvalid  out  1  one-cycle completion pulse to Fetch
- dreq  in  1  data request (level); held until dvalid
- dwe  in  1  1 = store, 0 = load; sampled at grant
- daddr  in  ADDR_W  data address, sampled at grant
- dwdata  in  DATA_W  store data, sampled at grant
- drdata  out  DATA_W  load data, valid while dvalid
- dvalid  out  1  one-cycle completion pulse to Memory stage
- stallF  out  1  ifreq & ~ifvalid
- stallM  out  1  dreq & ~dvalid
- memreq  out  1  request to memory; high for the whole access
- memwe  out  1  write enable to memory
- memaddr  out  ADDR_W  registered access address
- memwdata  out  DATA_W  registered write data
- memrdata  in  DATA_W  memory read data, valid with memack
- memack  in  1  one-cycle access-done pulse from memory
- conflict_cnt  out  CNT_W  cycles in which fetch waited while a data access owned memory (saturating)

## Operation
- FSM states: IDLE, GNT_D, GNT_I, RESP.
- IDLE, dreq=1: capture daddr/dwdata/dwe and go to GNT_D. Data always wins a tie because it belongs to the older instruction.
- IDLE, dreq=0, ifreq=1: capture ifaddr, set memwe=0, and go to GNT_I.
- IDLE, no request: stay in IDLE.
- GNT_D/GNT_I: memreq=1. memaddr/memwe/memwdata hold their captured values until memack.
- On memack in GNT_D: go to RESP and pulse dvalid. For a load, drdata<=memrdata. For a store, drdata is unchanged.
- On memack in GNT_I with ifreq still 1: go to RESP, ifvalid pulse, ifrdata<=memrdata.
- On memack in GNT_I with ifreq already 0 (killed fetch): discard the data, pulse no ifvalid, and go straight to IDLE.
- Killed fetch: dropping ifreq in GNT_I does not abort the access. memreq stays high until memack.
- RESP: lasts exactly one cycle with the valid pulse high, then IDLE. No new grant is made in RESP. The completing requester's request is still asserted in RESP and must not be re-granted.
- memack in IDLE or RESP is ignored.
- conflict_cnt increments in every cycle where state is GNT_D or RESP-after-data and ifreq=1. It saturates at 2^CNT_W-1.

## Timing
- Reset (rst=0, asynchronous): state=IDLE. memreq, memwe, ifvalid, dvalid, stallF-internal valids are 0. memaddr, memwdata, ifrdata, drdata, conflict_cnt are 0.
- Reset mid-access: memreq drops immediately (combinational from async-cleared state). The pending access is abandoned.
- Timeline: request seen in IDLE at edge k gives memreq high in cycle k+1. The earliest memack is in cycle k+1. The valid pulse comes in the cycle after memack.
- Minimum access is 3 cycles from request to valid (IDLE, GNT, RESP). Each extra memory wait cycle adds 1.
- Back-to-back requests: the next grant is decided in the IDLE cycle following RESP, giving 3 cycles per access minimum.
- stallF/stallM are combinational from registered valids. They fall in the valid cycle so the pipeline advances exactly once.

## Test plan
- Lone fetch: ifreq=1, ifaddr=0x40, memack 2 cycles after memreq with memrdata=0x8C010004. Required: memaddr=0x40, memwe=0, one ifvalid pulse with ifrdata=0x8C010004, stallF high until that cycle then low.
- Collision: ifreq and dreq (load, daddr=0x100) both rise the same cycle. Required: data is served first (memaddr=0x100, dvalid), then fetch (memaddr=ifaddr). conflict_cnt equals the GNT_D+RESP cycle count.
- Store: dwe=1, daddr=0x200, dwdata=0xDEADBEEF, memack delayed 4 cycles. Required: memwe=1 and memwdata=0xDEADBEEF held stable until memack, one dvalid pulse, drdata unchanged.
- Killed fetch: drop ifreq one cycle after GNT_I entry. Required: memreq stays high until memack, no ifvalid, FSM returns to IDLE. A following dreq is granted the next cycle.
- Async reset: assert rst=0 mid-GNT_D. Required: memreq=0 without waiting for a clock edge, all outputs 0, and a memack during reset is ignored.
- Saturation: CNT_W=4 with 20 conflict cycles. Required: conflict_cnt stops at 15.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline (Fetch / Memory stage), the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the pipeline-and-memory side.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifreq;
    logic [ADDR_W-1:0] ifaddr;
    logic [DATA_W-1:0] ifrdata;
    logic              ifvalid;
    logic              dreq;
    logic              dwe;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dwdata;
    logic [DATA_W-1:0] drdata;
    logic              dvalid;
    logic              stallF;
    logic              stallM;
    logic              memreq;
    logic              memwe;
    logic [ADDR_W-1:0] memaddr;
    logic [DATA_W-1:0] memwdata;
    logic [DATA_W-1:0] memrdata;
    logic              memack;

    modport slave (
        input  ifreq, ifaddr, dreq, dwe, daddr, dwdata, memrdata, memack,
        output ifrdata, ifvalid, drdata, dvalid, stallF, stallM,
               memreq, memwe, memaddr, memwdata
    );

    modport master (
        output ifreq, ifaddr, dreq, dwe, daddr, dwdata, memrdata, memack,
        input  ifrdata, ifvalid, drdata, dvalid, stallF, stallM,
               memreq, memwe, memaddr, memwdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access,
// data first, holding each request until memack and returning data with a one-cycle valid.
module unified_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    unified_mem_arbiter_if.slave bus,
    output logic [CNT_W-1:0]     conflict_cnt
);
    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_memaddr;
    logic [DATA_W-1:0] r_memwdata;
    logic              r_memwe;
    logic [DATA_W-1:0] r_ifrdata;
    logic [DATA_W-1:0] r_drdata;
    logic              r_ifvalid;
    logic              r_dvalid;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_done_d;
    logic              w_done_i;
    logic              w_conflict;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        w_done_d  = 1'b0;
        w_done_i  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.dreq) begin
                    w_next    = GNT_D;
                    w_grant_d = 1'b1;
                end else if (bus.ifreq) begin
                    w_next    = GNT_I;
                    w_grant_i = 1'b1;
                end
            end
            GNT_D: begin
                if (bus.memack) begin
                    w_next   = RESP;
                    w_done_d = 1'b1;
                end
            end
            GNT_I: begin
                // A fetch killed by a redirect still completes on the bus, but its data is dropped.
                if (bus.memack) begin
                    w_next   = bus.ifreq ? RESP : IDLE;
                    w_done_i = bus.ifreq;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // RESP following a data access is the cycle with dvalid high.
    assign w_conflict = bus.ifreq && ((r_state == GNT_D) || ((r_state == RESP) && r_dvalid));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_memaddr  <= '0;
            r_memwdata <= '0;
            r_memwe    <= 1'b0;
            r_ifrdata  <= '0;
            r_drdata   <= '0;
            r_ifvalid  <= 1'b0;
            r_dvalid   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_ifvalid <= w_done_i;
            r_dvalid  <= w_done_d;
            if (w_grant_d) begin
                r_memaddr  <= bus.daddr;
                r_memwdata <= bus.dwdata;
                r_memwe    <= bus.dwe;
            end else if (w_grant_i) begin
                r_memaddr <= bus.ifaddr;
                r_memwe   <= 1'b0;
            end
            if (w_done_d && !r_memwe) r_drdata <= bus.memrdata;
            if (w_done_i)             r_ifrdata <= bus.memrdata;
            if (w_conflict && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
        end
    end

    // memreq decodes the state directly so an async reset drops it without a clock edge.
    assign bus.memreq   = (r_state == GNT_D) || (r_state == GNT_I);
    assign bus.memwe    = r_memwe;
    assign bus.memaddr  = r_memaddr;
    assign bus.memwdata = r_memwdata;
    assign bus.ifrdata  = r_ifrdata;
    assign bus.ifvalid  = r_ifvalid;
    assign bus.drdata   = r_drdata;
    assign bus.dvalid   = r_dvalid;
    assign bus.stallF   = bus.ifreq & ~r_ifvalid;
    assign bus.stallM   = bus.dreq & ~r_dvalid;
    assign conflict_cnt = r_cnt;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run checked against a transaction-level reference model.
module tb_unified_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] conflict_cnt;
    int            checks = 0;
    int            errors = 0;

    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: who owns memory, what was captured, which valid fires this cycle.
    bit          m_busy, m_own_d, m_we, m_ifv, m_dv;
    logic [31:0] m_addr, m_wdata, m_ifrd, m_drd;
    int          m_cnt;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] exp_addr;
        bit          exp_we;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_own_d = 0; m_we = 0; m_ifv = 0; m_dv = 0;
        m_addr = '0; m_wdata = '0; m_ifrd = '0; m_drd = '0; m_cnt = 0;
    endtask

    // Advance the model by one clock using the inputs that were present before the edge.
    task automatic model_upd();
        bit was_resp;
        if (bus.ifreq && ((m_busy && m_own_d) || m_dv) && m_cnt < CMAX) m_cnt++;
        was_resp = m_ifv || m_dv;
        m_ifv = 0;
        m_dv  = 0;
        if (m_busy) begin
            if (bus.memack) begin
                m_busy = 0;
                if (m_own_d) begin
                    m_dv = 1;
                    if (!m_we) m_drd = bus.memrdata;
                end else if (bus.ifreq) begin
                    m_ifv  = 1;
                    m_ifrd = bus.memrdata;
                end
            end
        end else if (!was_resp) begin
            if (bus.dreq) begin
                m_busy = 1; m_own_d = 1;
                m_addr = bus.daddr; m_we = bus.dwe; m_wdata = bus.dwdata;
            end else if (bus.ifreq) begin
                m_busy = 1; m_own_d = 0;
                m_addr = bus.ifaddr; m_we = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_upd();
        else     model_reset();
        #1;
    endtask

    task automatic chk();
        @(negedge clk);
        cmp("memreq",       bus.memreq,  m_busy);
        cmp("ifvalid",      bus.ifvalid, m_ifv);
        cmp("dvalid",       bus.dvalid,  m_dv);
        cmp("stallF",       bus.stallF,  bus.ifreq & ~m_ifv);
        cmp("stallM",       bus.stallM,  bus.dreq & ~m_dv);
        cmp("ifrdata",      bus.ifrdata, m_ifrd);
        cmp("drdata",       bus.drdata,  m_drd);
        cmp("conflict_cnt", conflict_cnt, m_cnt);
        if (m_busy) begin
            cmp("memaddr", bus.memaddr, m_addr);
            cmp("memwe",   bus.memwe,   m_we);
            if (m_we) cmp("memwdata", bus.memwdata, m_wdata);
        end
    endtask

    task automatic idle_inputs();
        bus.ifreq = 0; bus.dreq = 0; bus.memack = 0;
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, " memreq"},   bus.memreq,   0);
        cmp({tag, " memwe"},    bus.memwe,    0);
        cmp({tag, " memaddr"},  bus.memaddr,  0);
        cmp({tag, " memwdata"}, bus.memwdata, 0);
        cmp({tag, " ifvalid"},  bus.ifvalid,  0);
        cmp({tag, " dvalid"},   bus.dvalid,   0);
        cmp({tag, " ifrdata"},  bus.ifrdata,  0);
        cmp({tag, " drdata"},   bus.drdata,   0);
        cmp({tag, " cnt"},      conflict_cnt, 0);
    endtask

    // One isolated access; memack arrives after v.dly extra GNT cycles.
    task automatic run_txn(input vec_t v);
        int n, g;
        bit got;
        tick();
        if (v.is_d) begin
            bus.dreq = 1; bus.dwe = v.we; bus.daddr = v.addr; bus.dwdata = v.wdata;
        end else begin
            bus.ifreq = 1; bus.ifaddr = v.addr;
        end
        bus.memack = 0;
        chk();
        n = 1; g = 0; got = 0;
        while (!got && n < 20) begin
            tick();
            n++;
            bus.memack = 0;
            if (bus.memreq) begin
                bus.memack   = (g == v.dly);
                bus.memrdata = v.rdata;
                cmp("txn memaddr", bus.memaddr, v.exp_addr);
                cmp("txn memwe",   bus.memwe,   v.exp_we);
                if (v.we) cmp("txn memwdata", bus.memwdata, v.wdata);
                g++;
            end
            chk();
            if (bus.ifvalid || bus.dvalid) got = 1;
        end
        cmp("txn completed",   got,        1);
        cmp("txn latency",     n,          v.exp_lat);
        cmp("txn valid is d",  bus.dvalid, v.is_d);
        cmp("txn return data", v.is_d ? bus.drdata : bus.ifrdata, v.exp_data);
        tick();
        idle_inputs();
        chk();
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        vec_t        vecs[5];
        logic [31:0] grants[4];
        int          ng, g, d_at, i_at, pdv, pifv;

        bus.ifaddr = '0; bus.daddr = '0; bus.dwdata = '0; bus.dwe = 0; bus.memrdata = '0;
        //          is_d we addr       wdata         rdata         dly exp_addr   we exp_data      lat
        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h8C010004, 2, 32'h40,  1'b0, 32'h8C010004, 5};
        vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h11223344, 0, 32'h100, 1'b0, 32'h11223344, 3};
        vecs[2] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 32'h55555555, 4, 32'h200, 1'b1, 32'h11223344, 7};
        vecs[3] = '{1'b0, 1'b0, 32'h44,  32'h0,        32'hA0B0C0D0, 0, 32'h44,  1'b0, 32'hA0B0C0D0, 3};
        vecs[4] = '{1'b1, 1'b0, 32'h104, 32'h0,        32'hCAFEF00D, 1, 32'h104, 1'b0, 32'hCAFEF00D, 4};

        do_reset();
        check_zero("reset");
        cmp("reset stallF", bus.stallF, 0);
        cmp("reset stallM", bus.stallM, 0);

        // Collision: data and fetch rise together; data served first.
        tick();
        bus.dreq = 1; bus.dwe = 0; bus.daddr = 32'h100;
        bus.ifreq = 1; bus.ifaddr = 32'h80;
        chk();
        ng = 0; g = 0; d_at = -1; i_at = -1;
        for (int n = 1; n < 30 && (d_at < 0 || i_at < 0); n++) begin
            tick();
            if (bus.dvalid) bus.dreq = 0;
            if (bus.ifvalid) bus.ifreq = 0;
            bus.memack = 0;
            if (bus.memreq) begin
                if (g == 0 && ng < 4) begin grants[ng] = bus.memaddr; ng++; end
                bus.memack   = (g == 1);
                bus.memrdata = bus.memaddr ^ 32'h5A5A5A5A;
                g++;
            end else g = 0;
            chk();
            if (bus.dvalid)  d_at = n;
            if (bus.ifvalid) i_at = n;
        end
        tick(); idle_inputs(); chk();
        cmp("collision grants", ng, 2);
        cmp("collision first grant", grants[0], 32'h100);
        cmp("collision second grant", grants[1], 32'h80);
        cmp("collision data first", (d_at > 0) && (i_at > d_at), 1);
        cmp("collision drdata", bus.drdata, 32'h100 ^ 32'h5A5A5A5A);
        cmp("collision ifrdata", bus.ifrdata, 32'h80 ^ 32'h5A5A5A5A);
        cmp("collision conflict_cnt", conflict_cnt, 3);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Killed fetch: ifreq drops during GNT_I, access still completes silently.
        tick(); bus.ifreq = 1; bus.ifaddr = 32'h300; chk();
        tick(); chk();
        cmp("kill grant memaddr", bus.memaddr, 32'h300);
        tick(); bus.ifreq = 0; chk();
        cmp("kill memreq held", bus.memreq, 1);
        tick(); bus.memack = 1; bus.memrdata = 32'hBADBAD00;
        bus.dreq = 1; bus.dwe = 0; bus.daddr = 32'h400; chk();
        cmp("kill memreq until ack", bus.memreq, 1);
        tick(); bus.memack = 0; chk();
        cmp("kill back to idle", bus.memreq, 0);
        cmp("kill no ifvalid", bus.ifvalid, 0);
        tick(); chk();
        cmp("kill next dreq granted", bus.memreq, 1);
        cmp("kill next dreq addr", bus.memaddr, 32'h400);
        tick(); bus.memack = 1; bus.memrdata = 32'h12345678; chk();
        tick(); bus.memack = 0; chk();
        cmp("kill load dvalid", bus.dvalid, 1);
        cmp("kill load drdata", bus.drdata, 32'h12345678);
        tick(); idle_inputs(); chk();

        // Async reset in the middle of a data grant.
        tick(); bus.dreq = 1; bus.dwe = 1; bus.daddr = 32'h500; bus.dwdata = 32'hFEEDFACE; chk();
        tick(); chk();
        cmp("areset pre memreq", bus.memreq, 1);
        #2;
        rst = 0;
        model_reset();
        #1;
        check_zero("areset immediate");
        bus.memack = 1;
        tick(); chk();
        check_zero("areset ack ignored");
        rst = 1;
        idle_inputs();
        tick(); chk();
        cmp("areset after release memreq", bus.memreq, 0);
        cmp("areset after release dvalid", bus.dvalid, 0);

        // Saturation: 20 conflict cycles on a 4-bit counter.
        tick(); bus.dreq = 1; bus.dwe = 0; bus.daddr = 32'h600;
        bus.ifreq = 1; bus.ifaddr = 32'h700; chk();
        for (int n = 0; n < 20; n++) begin tick(); chk(); end
        cmp("saturate cnt", conflict_cnt, CMAX);
        tick(); bus.memack = 1; bus.memrdata = 32'h0BADF00D; chk();
        tick(); bus.memack = 0; chk();
        tick(); idle_inputs(); chk();
        cmp("saturate cnt held", conflict_cnt, CMAX);

        // Randomized traffic with protocol-respecting requesters and noisy memack.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            pdv  = m_dv;
            pifv = m_ifv;
            tick();
            if (!bus.dreq || pdv != 0) bus.dreq = ($urandom_range(2) == 0);
            if (!bus.ifreq || pifv != 0) bus.ifreq = ($urandom_range(1) == 0);
            else if ($urandom_range(9) == 0) bus.ifreq = 0;
            bus.dwe      = $urandom_range(1);
            bus.daddr    = $urandom;
            bus.dwdata   = $urandom;
            bus.ifaddr   = $urandom;
            bus.memack   = ($urandom_range(2) == 0);
            bus.memrdata = $urandom;
            chk();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
